// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and widths for the 4-way round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int PTR_W   = 2;
  localparam int CNT_W   = 4;
  localparam int NUM_REQ = 4;

endpackage

// File: rtl/mux4_rr_pick.sv
// Combinational round-robin search: first set REQ bit starting at PTR, wrapping mod 4.
module mux4_rr_pick
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [PTR_W-1:0]   PTR,
  output logic               VALID,
  output logic [PTR_W-1:0]   IDX
);

  logic [NUM_REQ-1:0] rot;
  logic [PTR_W-1:0]   off;

  // rot[k] is the requester k positions after PTR in the search order
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign rot[gi] = REQ[PTR + PTR_W'(gi)];
  end

  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = PTR_W'(i);
    end
  end

  assign VALID = |rot;
  assign IDX   = PTR + off;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a 4:1 mux select; grants are held up to HOLD_MAX cycles.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic               CLK,
  input  logic               RN,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [NUM_REQ-1:0] LAST,
  output logic [NUM_REQ-1:0] GNT,
  output logic               S0,
  output logic               S1,
  output logic               BUSY
);

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   ptr_reg, ptr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [PTR_W-1:0]   sel_reg, sel_next;
  logic               busy_reg, busy_next;

  logic [PTR_W-1:0]   pick_ptr;
  logic               pick_valid;
  logic [PTR_W-1:0]   pick_idx;
  logic               release_now;

  // While granting, the search only matters on release, where it starts just past the winner
  assign pick_ptr = (state_reg == GRANT) ? sel_reg + PTR_W'(1) : ptr_reg;

  mux4_rr_pick u_pick (
    .REQ   (REQ),
    .PTR   (pick_ptr),
    .VALID (pick_valid),
    .IDX   (pick_idx)
  );

  assign release_now = !REQ[sel_reg] || LAST[sel_reg] ||
                       (cnt_reg == CNT_W'(HOLD_MAX));

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    gnt_next   = gnt_reg;
    sel_next   = sel_reg;
    busy_next  = busy_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = GRANT;
          gnt_next   = NUM_REQ'(1) << pick_idx;
          sel_next   = pick_idx;
          busy_next  = 1'b1;
          cnt_next   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_next = sel_reg + PTR_W'(1);
          if (pick_valid) begin
            gnt_next = NUM_REQ'(1) << pick_idx;
            sel_next = pick_idx;
            cnt_next = CNT_W'(1);
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
            busy_next  = 1'b0;
            cnt_next   = '0;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      gnt_reg   <= '0;
      sel_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      gnt_reg   <= gnt_next;
      sel_reg   <= sel_next;
      busy_reg  <= busy_next;
    end
  end

  assign GNT  = gnt_reg;
  assign S0   = sel_reg[0];
  assign S1   = sel_reg[1];
  assign BUSY = busy_reg;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed checks of the round-robin mux arbiter with HOLD_MAX = 4, 2 and 1.
module tb_mux4_rr_arbiter;

  logic       CLK;
  logic       RN;
  logic [3:0] req_a, last_a, gnt_a;
  logic       s0_a, s1_a, busy_a;
  logic [3:0] req_b, last_b, gnt_b;
  logic       s0_b, s1_b, busy_b;
  logic [3:0] req_c, last_c, gnt_c;
  logic       s0_c, s1_c, busy_c;

  int checks   = 0;
  int failures = 0;

  mux4_rr_arbiter #(.HOLD_MAX(4)) dut (
    .CLK(CLK), .RN(RN), .REQ(req_a), .LAST(last_a),
    .GNT(gnt_a), .S0(s0_a), .S1(s1_a), .BUSY(busy_a)
  );

  mux4_rr_arbiter #(.HOLD_MAX(2)) dut2 (
    .CLK(CLK), .RN(RN), .REQ(req_b), .LAST(last_b),
    .GNT(gnt_b), .S0(s0_b), .S1(s1_b), .BUSY(busy_b)
  );

  mux4_rr_arbiter #(.HOLD_MAX(1)) dut3 (
    .CLK(CLK), .RN(RN), .REQ(req_c), .LAST(last_c),
    .GNT(gnt_c), .S0(s0_c), .S1(s1_c), .BUSY(busy_c)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // Checks GNT, select and BUSY of the HOLD_MAX=4 instance together
  task automatic check_a(input string tag, input logic [3:0] g, input logic [1:0] s, input logic b);
    check({tag, " gnt"},  {4'h0, gnt_a},      {4'h0, g});
    check({tag, " sel"},  {6'h0, s1_a, s0_a}, {6'h0, s});
    check({tag, " busy"}, {7'h0, busy_a},     {7'h0, b});
  endtask

  initial begin
    logic [3:0] e_gnt;
    logic [1:0] e_idx;

    RN = 1'b0;
    req_a = 4'h0; last_a = 4'h0;
    req_b = 4'h0; last_b = 4'h0;
    req_c = 4'h0; last_c = 4'h0;
    #1;
    check_a("reset", 4'b0000, 2'd0, 1'b0);
    tick();
    RN = 1'b1;

    // Rotation with all requesting: 4 cycles each, back-to-back
    req_a = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      tick();
      e_idx = 2'(k / 4);
      e_gnt = 4'b0001 << e_idx;
      check_a($sformatf("rot%0d", k), e_gnt, e_idx, 1'b1);
    end

    // Drop all requests: idle with select held at 3
    req_a = 4'b0000;
    tick();
    check_a("idle_hold", 4'b0000, 2'd3, 1'b0);

    // Sole requester 3 then drop; pointer stays at 0 afterwards
    req_a = 4'b1000;
    tick();
    check_a("sole3", 4'b1000, 2'd3, 1'b1);
    req_a = 4'b0000;
    tick();
    check_a("drop3", 4'b0000, 2'd3, 1'b0);
    req_a = 4'b1001;
    tick();
    check_a("ptr0", 4'b0001, 2'd0, 1'b1);

    // Other REQ bits changing during a grant do not disturb it
    req_a = 4'b0011;
    tick();
    check_a("hold0", 4'b0001, 2'd0, 1'b1);
    // LAST of the winner on its second cycle hands over without a gap
    last_a = 4'b0001;
    tick();
    check_a("last_rel", 4'b0010, 2'd1, 1'b1);

    // Non-winner LAST bits are ignored; release only at hold expiry
    last_a = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_a($sformatf("ign_last%0d", k), 4'b0010, 2'd1, 1'b1);
    end
    tick();
    check_a("expire1", 4'b0001, 2'd0, 1'b1);

    // Hand over to requester 2, then reset in the middle of that grant
    last_a = 4'b0000;
    req_a  = 4'b0100;
    tick();
    check_a("w2", 4'b0100, 2'd2, 1'b1);
    #1 RN = 1'b0;
    #1;
    check_a("async_rst", 4'b0000, 2'd0, 1'b0);
    #1 RN = 1'b1;
    tick();
    check_a("post_rst", 4'b0100, 2'd2, 1'b1);
    req_a = 4'b0000;

    // HOLD_MAX=2 sole requester: continuous grant, CNT 1,2,1,2
    req_b = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("h2_gnt%0d", k), {4'h0, gnt_b}, 8'h04);
      check($sformatf("h2_cnt%0d", k), {4'h0, dut2.cnt_reg}, 8'((k % 2) + 1));
    end
    req_b = 4'b0000;

    // HOLD_MAX=1: one-cycle grants alternating between requesters 0 and 2
    req_c = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      tick();
      e_gnt = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      check($sformatf("h1_gnt%0d", k), {4'h0, gnt_c}, {4'h0, e_gnt});
      check($sformatf("h1_busy%0d", k), {7'h0, busy_c}, 8'h01);
    end
    req_c = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 4, meaning the maximum number of consecutive cycles one grant is held; legal range 1..15.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RN, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port REQ, input, 4, per-requester request; bit i = requester i wants mux input Ii.
REQ-005 SHALL have port LAST, input, 4, per-requester end-of-transfer flag; only LAST[winner] is examined.
REQ-006 SHALL have port GNT, output, 4, registered one-hot grant, or all-zero when idle.
REQ-007 SHALL have port S0, output, 1, registered mux select bit 0 (winner index bit 0).
REQ-008 SHALL have port S1, output, 1, registered mux select bit 1 (winner index bit 1).
REQ-009 SHALL have port BUSY, output, 1, registered; high exactly when GNT is non-zero.

Function
REQ-010 SHALL implement two states: IDLE (GNT=0) and GRANT (GNT one-hot, index W).
REQ-011 SHALL keep a 2-bit round-robin pointer PTR; the search order is PTR, PTR+1, PTR+2, PTR+3 (mod 4); the first set REQ bit wins.
REQ-012 In IDLE with REQ non-zero at an edge, SHALL enter GRANT at that edge: GNT=onehot(W), {S1,S0}=W, BUSY=1, CNT=1. Latency is one cycle from REQ to GNT.
REQ-013 In GRANT, SHALL release at an edge when any of: REQ[W]=0, LAST[W]=1, or CNT==HOLD_MAX.
REQ-014 If no release occurs, SHALL hold GNT and S unchanged and increment CNT (4-bit, no wrap within the legal range).
REQ-015 On release, SHALL set PTR=W+1 (mod 4) and re-arbitrate in the same edge over the current REQ with the updated PTR. W itself is searched last.
REQ-016 If the REQ-015 re-arbitration finds a winner, SHALL grant it with no idle bubble and set CNT=1; otherwise SHALL go to IDLE.
REQ-017 In IDLE, S1/S0 SHALL hold the last granted index so the mux output stays stable. GNT and BUSY SHALL be 0.
REQ-018 A requester that remains sole requester after a HOLD_MAX expiry SHALL be re-granted the next cycle with CNT=1 (GNT stays high, no gap).
REQ-019 REQ bits that change during GRANT SHALL not affect GNT, except REQ[W] per REQ-013.
REQ-020 LAST of non-winning requesters SHALL be ignored.
REQ-021 HOLD_MAX=1 SHALL produce one-cycle grants rotating every cycle among all active requesters.

Reset
REQ-022 RN low SHALL immediately, without waiting for CLK, force: GNT=0, S0=0, S1=0, BUSY=0, PTR=0, CNT=0, state IDLE. This includes assertion in the middle of a grant.
REQ-023 After RN deasserts, the first arbitration SHALL start from PTR=0.

Structure
REQ-024 A shared package SHALL hold the state enum (IDLE, GRANT), the PTR width constant (2), the CNT width constant (4) and the requester-count constant (4).
REQ-025 The round-robin search SHALL be a combinational sub-module mux4_rr_pick: inputs REQ[3:0] and PTR[1:0]; outputs a valid flag and the 2-bit index.
REQ-026 All outputs SHALL be driven directly from flops.

Verification
REQ-027 Reset mid-grant: W=2, RN pulses low between edges -> GNT=0000, S=00 and BUSY=0 asynchronously; after release, REQ=0100 -> GNT=0100 one edge later.
REQ-028 Rotation: REQ=1111 held, LAST=0, HOLD_MAX=4 -> grants 0001, 0010, 0100, 1000, each exactly 4 cycles, back-to-back. {S1,S0} steps 0,1,2,3.
REQ-029 LAST release: REQ=0011, grant to 0, LAST[0]=1 on its second grant cycle -> GNT=0010 at the next edge with no BUSY gap.
REQ-030 Request drop: sole REQ=1000 granted, REQ drops to 0 -> IDLE next edge with GNT=0 and {S1,S0}=11 held; then REQ=1001 -> grant 0 (PTR=0).
REQ-031 Sole requester expiry: HOLD_MAX=2, REQ=0100 held -> GNT stays 0100 continuously and CNT sequence is 1,2,1,2.
REQ-032 Ignored LAST: W=1 with LAST=1101 (LAST[1]=0) -> no release until CNT==HOLD_MAX.
